// File: rtl/uart_tx_arb_if.sv
// uart_tx_arb_if: request/ack handshake of two byte sources plus the uart_tx launch/done pair.
interface uart_tx_arb_if;
  logic       req0;
  logic       req1;
  logic       ack0;
  logic       ack1;
  logic       trmt;
  logic       tx_done;
  logic       busy;
  logic       tx_err;
  logic [7:0] tx_data0;
  logic [7:0] tx_data1;
  logic [7:0] tx_data;
  modport master (
    output req0, tx_data0, req1, tx_data1, tx_done,
    input  ack0, ack1, trmt, tx_data, busy, tx_err
  );
  modport slave (
    input  req0, tx_data0, req1, tx_data1, tx_done,
    output ack0, ack1, trmt, tx_data, busy, tx_err
  );
endinterface

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter sharing one uart_tx between two byte sources.
// Define UART_ARB_TIMEOUT_EN to abort a WAIT after TIMEOUT_CYC cycles with a tx_err pulse.
module uart_tx_arb #(
  parameter logic [15:0] TIMEOUT_CYC = 16'd4096
) (
  input logic          clk,
  input logic          rst,
  uart_tx_arb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;
  state_t state;
  state_t state_next;
  logic   gnt_id;
  logic   last;
  logic   tx_done_q;
  logic   done_ev;
  logic   pick;
  logic   timed_out;
  logic   trmt_next;
  logic   busy_next;
  logic   ack0_next;
  logic   ack1_next;
  logic   err_next;
  // only a rising tx_done counts, so a level left high by the previous frame is ignored
  assign done_ev = bus.tx_done & ~tx_done_q;
  assign pick    = (bus.req0 & bus.req1) ? ~last : bus.req1;
`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0] cnt;
  assign timed_out = cnt == TIMEOUT_CYC - 16'd1;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else     cnt <= (state == WAIT) ? cnt + 16'd1 : '0;
`else
  assign timed_out = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      bus.trmt   <= 1'b0;
      bus.busy   <= 1'b0;
      bus.ack0   <= 1'b0;
      bus.ack1   <= 1'b0;
      bus.tx_err <= 1'b0;
    end else begin
      state      <= state_next;
      bus.trmt   <= trmt_next;
      bus.busy   <= busy_next;
      bus.ack0   <= ack0_next;
      bus.ack1   <= ack1_next;
      bus.tx_err <= err_next;
    end
  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = (bus.req0 | bus.req1) ? SEND : IDLE;
      SEND: state_next = WAIT;
      WAIT: state_next = (done_ev | timed_out) ? DONE : WAIT;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end
  // outputs are computed from the next state so they land in flops aligned with it
  always_comb begin
    trmt_next = state_next == SEND;
    busy_next = state_next != IDLE;
    ack0_next = (state_next == DONE) & ~gnt_id;
    ack1_next = (state_next == DONE) & gnt_id;
`ifdef UART_ARB_TIMEOUT_EN
    err_next  = (state == WAIT) & (state_next == DONE) & ~done_ev;
`else
    err_next  = 1'b0;
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.tx_data <= 8'h00;
      gnt_id      <= 1'b0;
      last        <= 1'b1;
      tx_done_q   <= 1'b0;
    end else begin
      tx_done_q <= bus.tx_done;
      if (state == IDLE && (bus.req0 | bus.req1)) begin
        bus.tx_data <= pick ? bus.tx_data1 : bus.tx_data0;
        gnt_id      <= pick;
        last        <= pick;
      end
    end
endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Two-port round-robin arbiter and sequencer that shares a single `uart_tx` serializer between two byte sources. Typical sources are the command-response path and the captured-sample dump path. The block latches the winning requester's byte, issues a one-cycle `trmt` launch, and waits for the serializer's `tx_done` rising edge. It then returns a one-cycle acknowledge to the requester that won. It sits between the capture/command logic and `uart_tx`, in the same clock domain as `UART_trig_rx`.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 16'd4096: cycles allowed in WAIT before abort. Applies only when `UART_ARB_TIMEOUT_EN` is defined. Legal range 2..65535.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0`  in  1  requester 0 byte request (level).
- `tx_data0`  in  8  requester 0 byte.
- `ack0`  out  1  one-cycle pulse: requester 0 byte finished.
- `req1`  in  1  requester 1 byte request (level).
- `tx_data1`  in  8  requester 1 byte.
- `ack1`  out  1  one-cycle pulse: requester 1 byte finished.
- `trmt`  out  1  one-cycle launch strobe to `uart_tx`.
- `tx_data`  out  8  byte to `uart_tx`; registered and stable from SEND through DONE.
- `tx_done`  in  1  `uart_tx` done level. The serializer clears it after `trmt` and sets it when the stop bit ends.
- `busy`  out  1  high in any state other than IDLE.
- `tx_err`  out  1  one-cycle pulse: the granted byte timed out (timeout build only).

## Operation
- State machine states: IDLE, SEND, WAIT, DONE. All outputs are registered.
- IDLE:
  - If exactly one `reqN` is high, grant N.
  - If both are high, grant the port that was not granted last (pointer `last`).
  - On a grant: latch `tx_dataN` into `tx_data`, store `gnt_id`, set `last` to N, go to SEND.
  - If no request is high, stay in IDLE.
- SEND: `trmt`=1 for exactly this cycle, then go to WAIT.
- WAIT:
  - The done event is `tx_done & ~tx_done_q`, where `tx_done_q` is the previous-cycle value of `tx_done`.
  - On the done event, go to DONE.
  - A `tx_done` level that is already high on entry to WAIT is not an event.
- DONE: the ack for `gnt_id` is 1 for exactly this cycle, then go to IDLE.
- Requester rules:
  - Hold `reqN` and `tx_dataN` stable until the `ackN` cycle.
  - Sample `ackN` at the closing edge of that cycle and drop or renew `reqN` at that same edge.
  - A request still high in the IDLE cycle after DONE is treated as a new byte.
- Requests arriving during SEND, WAIT or DONE are not lost. They are evaluated in the next IDLE.
- A `reqN` that is dropped before its ack does not abort a byte already in SEND or WAIT. The byte completes and `ackN` still pulses.

## Timing
- Reset values:
  - State is IDLE.
  - `trmt`, `ack0`, `ack1`, `busy` and `tx_err` are 0.
  - `tx_data` is 8'h00 and `tx_done_q` is 0.
  - `last` is 1, so `req0` wins the first tie.
- Launch latency: a request sampled high in IDLE at edge k gives `trmt`=1 in the cycle after edge k. `busy` rises at edge k.
- Completion latency: a done event in cycle m gives the ack during cycle m+1. The block is back in IDLE at cycle m+2.
- Minimum spacing between consecutive `trmt` pulses equals one serializer frame plus 3 cycles.
- Both requests rising in the same cycle: the grant alternates strictly (0,1,0,1…) while both remain asserted.
- Reset mid-operation returns the block to IDLE within the same cycle (asynchronous):
  - Any pending ack is discarded.
  - `tx_data` clears and `last` returns to 1.
  - The serializer is reset independently.
- `tx_done` must never rise during SEND. If it does, the block ignores it.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches `TIMEOUT_CYC`-1 with no done event, the block goes to DONE.
  - In that DONE cycle, `tx_err`=1 and the granted `ackN`=1.
  - `last` still advances as normal.
- `UART_ARB_TIMEOUT_EN` not defined:
  - No counter is built and `tx_err` is tied to 0.
  - WAIT is held indefinitely until the done event.

## Test plan
- Single request: `req0`=1 with `tx_data0`=8'h55, serializer at `baud_cnt`=108. Expected: one `trmt` pulse, 8'h55 received on the loopback `UART_trig_rx`, `ack0` exactly one cycle, `ack1` never.
- Tie: `req0` and `req1` high in the same cycle with 8'hA5 and 8'h3C, each held until its ack. Expected: A5 sent first then 3C, `ack0` then `ack1`, three cycles of idle gap plus frame time between launches.
- Fairness: both held high for 4 bytes. Expected: grant sequence 0,1,0,1, and no `trmt` while `busy` is high in WAIT.
- Late request: `req1` rises during WAIT of a port-0 byte. Expected: the port-0 ack, then port-1 launched in the IDLE cycle that follows DONE, then port-1 ack.
- Async reset: assert `rst` mid-WAIT. Expected: all outputs 0 immediately, no ack pulse. A new `req1` after release completes normally.
- Timeout (macro defined, `TIMEOUT_CYC`=16'd32): `tx_done` held low. Expected: `tx_err` and `ack0` pulse together after 32 cycles in WAIT, then return to IDLE.
